// File: rtl/sna_pkg.sv
// Shared flit-type encodings and depacketizer FSM states.
package sna_pkg;

  typedef enum logic [1:0] {
    FT_ADDR = 2'b00,
    FT_DATA = 2'b01,
    FT_HEAD = 2'b10,
    FT_RSVD = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EXP_ADDR = 2'b01,
    ST_EXP_DATA = 2'b10,
    ST_HOLD     = 2'b11
  } dp_state_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sna_flit_depacketizer.sv
// Reassembles HEAD/ADDR[/DATA] NoC flits into a single read or write request
// and holds it until the downstream master takes it. Malformed sequences are
// dropped and reported through proto_err / err_count.
module sna_flit_depacketizer
  import sna_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int POV_W   = 4,
  parameter int POV_LSB = 24,
  parameter int FLIT_W  = DATA_W + 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] flit_in_data,
  input  logic              flit_in_valid,
  output logic              flit_in_ready,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_read,
  output logic [DATA_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  output logic [POV_W-1:0]  req_src,
  output logic              proto_err,
  output logic [7:0]        err_count
);

  dp_state_e         state_q, state_d;
  logic              read_q, read_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [POV_W-1:0]  src_q, src_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              accept;
  logic              bad;
  flit_type_e        ftype;
  logic [DATA_W-1:0] payload;
  logic              head_read;
  logic [POV_W-1:0]  head_src;
  logic              unused_flit;

  assign ftype     = flit_type_e'(flit_in_data[FLIT_W-1:FLIT_W-2]);
  assign payload   = flit_in_data[DATA_W-1:0];
  assign head_read = flit_in_data[0];
  assign head_src  = flit_in_data[POV_LSB+POV_W-1:POV_LSB];
  // Only some flit bits carry meaning depending on the flit type.
  assign unused_flit = ^flit_in_data;

  assign flit_in_ready = (state_q != ST_HOLD);
  assign accept        = flit_in_valid && flit_in_ready;

  assign req_valid = (state_q == ST_HOLD);
  assign req_read  = read_q;
  assign req_addr  = addr_q;
  assign req_data  = data_q;
  assign req_src   = src_q;
  assign proto_err = err_q;
  assign err_count = cnt_q;

  // Next-state decode: flit sequencing, field capture and violation detection.
  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    addr_d  = addr_q;
    data_d  = data_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    bad     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ftype == FT_HEAD) begin
            read_d  = head_read;
            src_d   = head_src;
            data_d  = '0;
            state_d = ST_EXP_ADDR;
          end else begin
            bad = 1'b1;
          end
        end
      end
      ST_EXP_ADDR, ST_EXP_DATA: begin
        if (accept) begin
          if (ftype == FT_HEAD) begin
            // A fresh head restarts assembly; the partial packet is lost.
            read_d  = head_read;
            src_d   = head_src;
            data_d  = '0;
            state_d = ST_EXP_ADDR;
            bad     = 1'b1;
          end else if (state_q == ST_EXP_ADDR && ftype == FT_ADDR) begin
            addr_d  = payload;
            state_d = read_q ? ST_HOLD : ST_EXP_DATA;
          end else if (state_q == ST_EXP_DATA && ftype == FT_DATA) begin
            data_d  = payload;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
            bad     = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (req_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = bad;
    if (bad && cnt_q != ERR_CNT_MAX) cnt_d = cnt_q + 8'd1;
  end

  // FSM and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      read_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      src_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      src_q   <= src_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sna_flit_depacketizer.sv
// Directed bench with a request scoreboard and an error-pulse monitor.
module tb_sna_flit_depacketizer;

  localparam int DATA_W = 32;
  localparam int POV_W  = 4;
  localparam int FLIT_W = DATA_W + 5;

  localparam logic [1:0] T_ADDR = 2'b00;
  localparam logic [1:0] T_DATA = 2'b01;
  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_RSVD = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [FLIT_W-1:0] flit_in_data;
  logic              flit_in_valid;
  logic              flit_in_ready;
  logic              req_valid;
  logic              req_ready;
  logic              req_read;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [POV_W-1:0]  req_src;
  logic              proto_err;
  logic [7:0]        err_count;

  typedef struct packed {
    logic              rd;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [POV_W-1:0]  src;
  } req_t;

  req_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   perr_seen = 0;
  int   exp_perr = 0;
  int   hs_count = 0;
  int   exp_cnt = 0;

  sna_flit_depacketizer #(
    .DATA_W(DATA_W), .POV_W(POV_W), .POV_LSB(24), .FLIT_W(FLIT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .flit_in_data(flit_in_data), .flit_in_valid(flit_in_valid),
    .flit_in_ready(flit_in_ready),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_addr(req_addr), .req_data(req_data),
    .req_src(req_src), .proto_err(proto_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [31:0] p);
    return {t, 3'b000, p};
  endfunction

  task automatic send(input logic [1:0] t, input logic [31:0] p);
    int n = 0;
    @(negedge clk);
    flit_in_data  = mk(t, p);
    flit_in_valid = 1'b1;
    while (!flit_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: flit_in_ready stuck at 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1 flit_in_valid = 1'b0;
  endtask

  task automatic note_err();
    exp_perr++;
    if (exp_cnt < 255) exp_cnt++;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic push(input logic rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_t r;
    r.rd = rd; r.addr = a; r.data = d; r.src = s;
    exp_q.push_back(r);
  endtask

  // Monitor: counts error pulses and checks each handshaken request.
  always @(negedge clk) begin
    if (rst_n) begin
      if (proto_err) perr_seen++;
      if (req_valid && req_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr 0x%0h src %0d, expected no request", req_addr, req_src);
        end else begin
          req_t e;
          e = exp_q.pop_front();
          chk("req_read", 64'(req_read), 64'(e.rd));
          chk("req_addr", 64'(req_addr), 64'(e.addr));
          chk("req_data", 64'(req_data), 64'(e.data));
          chk("req_src",  64'(req_src),  64'(e.src));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    flit_in_valid = 1'b0;
    flit_in_data = '0;
    req_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_req_addr",  64'(req_addr),  64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(flit_in_ready), 64'd1);

    // Read packet: HEAD 0x10_0500_0001, ADDR 0x00_4000_0010
    push(1'b1, 32'h4000_0010, 32'h0, 4'd5);
    send(T_HEAD, 32'h0500_0001);
    send(T_ADDR, 32'h4000_0010);
    chk("read_latency_valid", 64'(req_valid), 64'd1);
    settle();

    // Write packet with back-pressure for 3 cycles
    req_ready = 1'b0;
    push(1'b0, 32'h8, 32'hDEAD_BEEF, 4'd3);
    send(T_HEAD, 32'h0300_0000);
    send(T_ADDR, 32'h0000_0008);
    send(T_DATA, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(req_valid), 64'd1);
      chk("hold_ready", 64'(flit_in_ready), 64'd0);
      chk("hold_addr",  64'(req_addr), 64'h8);
      chk("hold_data",  64'(req_data), 64'hDEAD_BEEF);
    end
    @(posedge clk); #1 req_ready = 1'b1;
    settle();
    chk("wr_back_idle_valid", 64'(req_valid), 64'd0);
    chk("wr_back_idle_ready", 64'(flit_in_ready), 64'd1);
    chk("wr_handshakes", 64'(hs_count), 64'd2);

    // DATA flit in IDLE
    send(T_DATA, 32'h0000_1234);
    note_err();
    settle();
    chk("idle_data_perr", 64'(perr_seen), 64'(exp_perr));
    chk("idle_data_cnt",  64'(err_count), 64'd1);
    chk("idle_data_novalid", 64'(req_valid), 64'd0);

    // HEAD interrupted by a second HEAD
    push(1'b1, 32'h20, 32'h0, 4'd7);
    send(T_HEAD, 32'h0200_0001);
    send(T_HEAD, 32'h0700_0001);
    note_err();
    send(T_ADDR, 32'h0000_0020);
    settle();
    chk("rehead_perr", 64'(perr_seen), 64'(exp_perr));
    chk("rehead_cnt",  64'(err_count), 64'd2);

    // DATA while expecting ADDR returns to IDLE
    send(T_HEAD, 32'h0100_0000);
    send(T_DATA, 32'h0000_0055);
    note_err();
    push(1'b1, 32'h44, 32'h0, 4'd9);
    send(T_HEAD, 32'h0900_0001);
    send(T_ADDR, 32'h0000_0044);
    settle();
    chk("wrong_type_perr", 64'(perr_seen), 64'(exp_perr));
    chk("wrong_type_cnt",  64'(err_count), 64'(exp_cnt));

    // Reset while in EXP_DATA
    send(T_HEAD, 32'h0A00_0000);
    send(T_ADDR, 32'h0000_0099);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(req_valid), 64'd0);
    chk("mid_rst_read",  64'(req_read),  64'd0);
    chk("mid_rst_addr",  64'(req_addr),  64'd0);
    chk("mid_rst_data",  64'(req_data),  64'd0);
    chk("mid_rst_src",   64'(req_src),   64'd0);
    chk("mid_rst_perr",  64'(proto_err), 64'd0);
    chk("mid_rst_cnt",   64'(err_count), 64'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(flit_in_ready), 64'd1);
    push(1'b1, 32'h77, 32'h0, 4'd6);
    send(T_HEAD, 32'h0600_0001);
    send(T_ADDR, 32'h0000_0077);
    settle();
    chk("post_rst_cnt", 64'(err_count), 64'd0);

    // 300 RESERVED flits saturate the counter
    for (int i = 0; i < 300; i++) begin
      send(T_RSVD, 32'(i));
      note_err();
    end
    settle();
    chk("sat_cnt",  64'(err_count), 64'd255);
    chk("sat_perr", 64'(perr_seen), 64'(exp_perr));

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("total_handshakes", 64'(hs_count), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sna_flit_depacketizer.md
SNA_FLIT_DEPACKETIZER -- requirements
Module: sna_flit_depacketizer

Interface
REQ-001 Parameter DATA_W, default 32: address and write-data payload width; address width equals DATA_W.
REQ-002 Parameter POV_W, default 4: source (point-of-view) address width.
REQ-003 Parameter POV_LSB, default 24: LSB position of the source field inside a head flit.
REQ-004 Parameter FLIT_W, default DATA_W+5: flit width; type field is bits [FLIT_W-1:FLIT_W-2].
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 flit_in_data  in  FLIT_W  incoming NoC flit.
REQ-008 flit_in_valid  in  1  flit present.
REQ-009 flit_in_ready  out  1  block accepts flit this cycle.
REQ-010 req_valid  out  1  assembled request available.
REQ-011 req_ready  in  1  downstream AXI4-Lite master accepts the request.
REQ-012 req_read  out  1  1 = read, 0 = write.
REQ-013 req_addr  out  DATA_W  request address.
REQ-014 req_data  out  DATA_W  write data; all zeros for reads.
REQ-015 req_src  out  POV_W  requesting node address.
REQ-016 proto_err  out  1  one-cycle pulse per protocol violation.
REQ-017 err_count  out  8  saturating count of protocol violations.

Function
REQ-018 Flit types: 2'b10 HEAD, 2'b00 ADDR, 2'b01 DATA, 2'b11 RESERVED.
REQ-019 HEAD payload: read = bit 0; src = bits [POV_LSB+POV_W-1:POV_LSB]; all other bits ignored.
REQ-020 ADDR and DATA payload: bits [DATA_W-1:0].
REQ-021 Packet formats: read = HEAD, ADDR; write = HEAD, ADDR, DATA.
REQ-022 A flit is accepted only in a cycle where flit_in_valid and flit_in_ready are both 1.
REQ-023 FSM states: IDLE (expects HEAD), EXP_ADDR, EXP_DATA, HOLD (req_valid=1).
REQ-024 flit_in_ready = 1 in IDLE, EXP_ADDR and EXP_DATA; 0 in HOLD.
REQ-025 IDLE + HEAD: latch read and src, clear data register, go to EXP_ADDR.
REQ-026 EXP_ADDR + ADDR: latch addr; if read, go to HOLD; otherwise go to EXP_DATA.
REQ-027 EXP_DATA + DATA: latch data, go to HOLD.
REQ-028 req_valid rises on the cycle after the final flit is accepted; minimum latency 1 cycle.
REQ-029 HOLD: all req_* outputs stay stable; on req_valid and req_ready both 1, go to IDLE on the next edge.
REQ-030 Non-HEAD flit in IDLE: drop it, pulse proto_err, stay in IDLE.
REQ-031 HEAD flit in EXP_ADDR or EXP_DATA: abandon the partial packet, pulse proto_err, latch the new head, go to EXP_ADDR.
REQ-032 DATA in EXP_ADDR, or ADDR in EXP_DATA: drop it, pulse proto_err, go to IDLE.
REQ-033 RESERVED flit in any accepting state: drop it, pulse proto_err, go to IDLE.
REQ-034 proto_err is registered, asserts the cycle after the offending acceptance, and lasts exactly 1 cycle.
REQ-035 err_count increments by 1 with each proto_err pulse and saturates at 255.
REQ-036 Flits presented with flit_in_valid=0 have no effect on state.

Reset
REQ-037 While rst_n=0: state = IDLE; req_valid, req_read, req_addr, req_data, req_src, proto_err and err_count = 0.
REQ-038 Reset asserted mid-packet or in HOLD discards the request without emitting it.
REQ-039 flit_in_ready = 1 from the first edge after rst_n deasserts.

Structure
REQ-040 Flit-type constants and the FSM state enumeration live in the shared package sna_pkg.
REQ-041 Single module; no sub-module is required.
REQ-042 FSM and output registers use one sequential process; next-state logic is purely combinational.

Verification
REQ-043 Read: HEAD 0x10_0500_0001 (src 5, read 1), then ADDR 0x00_4000_0010 -> req_valid 1 cycle later, read=1, addr=0x40000010, src=5, data=0.
REQ-044 Write with req_ready held 0 for 3 cycles: HEAD read=0, src 3; ADDR 0x8; DATA 0xDEADBEEF -> outputs stable while flit_in_ready=0 for those 3 cycles; single handshake, then return to IDLE.
REQ-045 DATA flit in IDLE -> proto_err pulses once, err_count=1, no req_valid.
REQ-046 HEAD, then a second HEAD (src 7) before ADDR, then ADDR 0x20 -> one proto_err; request emitted with src=7, addr=0x20.
REQ-047 rst_n pulled low while in EXP_DATA -> all outputs 0; a following complete read packet is assembled correctly.
REQ-048 300 RESERVED flits -> err_count saturates at 255 and does not wrap.
